// File: rtl/pim_mac_tile_pkg.sv
// pim_mac_tile_pkg: FSM state type and counter sizing helper for the PIM MAC tile.
package pim_mac_tile_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} pim_tile_state_e;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pim_mac_tile_lane.sv
// pim_mac_lane: one unsigned MAC step, product truncated to the accumulator width and summed modulo 2^ACC_WIDTH.
module pim_mac_lane #(
    parameter int ELEM_WIDTH = 32,
    parameter int ACC_WIDTH = 32
) (
    input  logic [ELEM_WIDTH-1:0] a,
    input  logic [ELEM_WIDTH-1:0] b,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    output logic [ACC_WIDTH-1:0]  acc_out
);
    logic [2*ELEM_WIDTH-1:0] prod;
    assign prod = (2*ELEM_WIDTH)'(a) * (2*ELEM_WIDTH)'(b);
    assign acc_out = acc_in + ACC_WIDTH'(prod);
endmodule

// File: rtl/pim_mac_tile.sv
// pim_mac_tile: multi-cycle NxN unsigned matrix multiply-accumulate over LANES MACs,
// with valid/ready handshakes on both the job input and the held result.
module pim_mac_tile
    import pim_mac_tile_pkg::*;
#(
    parameter int ID = 0,
    parameter int ELEM_WIDTH = 32,
    parameter int ACC_WIDTH = 32,
    parameter int PIM_MATRIX_SIZE = 8,
    parameter int LANES = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              acc_en,
    input  logic [ELEM_WIDTH*PIM_MATRIX_SIZE*PIM_MATRIX_SIZE-1:0] matrixA,
    input  logic [ELEM_WIDTH*PIM_MATRIX_SIZE*PIM_MATRIX_SIZE-1:0] matrixB,
    output logic [ACC_WIDTH*PIM_MATRIX_SIZE*PIM_MATRIX_SIZE-1:0]  result,
    output logic                                              result_valid,
    input  logic                                              result_ready,
    output logic [31:0]                                       result_id,
    output logic                                              busy
);
    localparam int N = PIM_MATRIX_SIZE;
    localparam int G = N / LANES;
    localparam int IW = cnt_w(N);
    localparam int GW = cnt_w(G);

    if (N % LANES != 0) begin : g_bad_lanes
        $error("pim_mac_tile: LANES must divide PIM_MATRIX_SIZE");
    end
    if (ACC_WIDTH < ELEM_WIDTH) begin : g_bad_acc
        $error("pim_mac_tile: ACC_WIDTH must be >= ELEM_WIDTH");
    end

    pim_tile_state_e state, state_nxt;
    logic [IW-1:0] i, k;
    logic [GW-1:0] g;
    logic [ELEM_WIDTH-1:0] a_m [N][N];
    logic [ELEM_WIDTH-1:0] b_m [N][N];
    logic [ACC_WIDTH-1:0] res [N][N];
    logic [ACC_WIDTH-1:0] sum [LANES];
    logic [IW-1:0] col [LANES];
    logic k_last, g_last, i_last;

    assign k_last = k == IW'(N - 1);
    assign g_last = g == GW'(G - 1);
    assign i_last = i == IW'(N - 1);

    // Lane l handles column g*LANES+l of row i for the current k.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign col[l] = IW'(int'(g) * LANES + l);
        pim_mac_lane #(.ELEM_WIDTH(ELEM_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
            .a(a_m[i][k]),
            .b(b_m[k][col[l]]),
            .acc_in(res[i][col[l]]),
            .acc_out(sum[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            i <= '0;
            g <= '0;
            k <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    res[r][c] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                i <= '0;
                g <= '0;
                k <= '0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        a_m[r][c] <= matrixA[(r*N+c)*ELEM_WIDTH +: ELEM_WIDTH];
                        b_m[r][c] <= matrixB[(r*N+c)*ELEM_WIDTH +: ELEM_WIDTH];
                        if (!acc_en)
                            res[r][c] <= '0;
                    end
            end
            if (state == COMPUTE) begin
                for (int l = 0; l < LANES; l++)
                    res[i][col[l]] <= sum[l];
                k <= k_last ? '0 : k + 1'b1;
                if (k_last) begin
                    g <= g_last ? '0 : g + 1'b1;
                    if (g_last)
                        i <= i_last ? '0 : i + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? COMPUTE : IDLE;
            COMPUTE: state_nxt = (i_last && g_last && k_last) ? DONE : COMPUTE;
            DONE:    state_nxt = result_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == IDLE;
        busy = state == COMPUTE;
        result_valid = state == DONE;
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign result[(r*N+c)*ACC_WIDTH +: ACC_WIDTH] = res[r][c];
        end
    end

    assign result_id = 32'(ID);
endmodule

// File: doc/pim_mac_tile.md
# pim_mac_tile

Multi-cycle, parametrised successor to the single-cycle PIM multiply unit. It computes an N×N unsigned matrix product using a configurable number of MAC lanes, and can optionally accumulate onto the previous result so that K-dimension tiling is handled inside the unit. The block sits between the partition logic, through a valid/ready input handshake, and the result aggregator, through a valid/ready output handshake that holds the result until it is accepted.

## Interface
Parameters:
- `ID`, 0, tile identifier; informational only and passed through to `result_id`.
- `ELEM_WIDTH`, 32, width of each operand element.
- `ACC_WIDTH`, 32, width of each result element; must be ≥ ELEM_WIDTH.
- `PIM_MATRIX_SIZE` (N), 8, matrix dimension.
- `LANES`, 8, number of parallel MACs; must divide N, otherwise elaboration fails with `$error`.

Ports:
- `clk`  in  1  — single clock; all logic is rising-edge.
- `rst`  in  1  — reset; synchronous and active-high.
- `in_valid`  in  1  — operands and `acc_en` are valid.
- `in_ready`  out  1  — unit can accept a new job.
- `acc_en`  in  1  — 1: add the product onto the held result; 0: overwrite the held result.
- `matrixA`  in  ELEM_WIDTH × N × N  — left operand.
- `matrixB`  in  ELEM_WIDTH × N × N  — right operand.
- `result`  out  ACC_WIDTH × N × N  — result matrix.
- `result_valid`  out  1  — result is complete and stable.
- `result_ready`  in  1  — aggregator accepts the result.
- `result_id`  out  32  — constant `ID`.
- `busy`  out  1  — state is COMPUTE.

## Operation
- FSM states, held in `pim_tile_state_e`: IDLE, COMPUTE, DONE.
- IDLE: `in_ready`=1. When `in_valid` is high:
  - latch A, B and `acc_en` into internal registers;
  - if `acc_en`=0, clear `result` to 0 on the same edge;
  - go to COMPUTE, with counters i, g and k all set to 0.
- COMPUTE: each cycle, for each lane l (0..LANES-1), with j = g·LANES + l:
  - `result[i][j] <= result[i][j] + A[i][k]·B[k][j]`.
- Iteration order: k is innermost, then g (0..N/LANES-1), then i is outermost.
- When i=N-1, g=N/LANES-1 and k=N-1, go to DONE.
- DONE: `result_valid`=1 and `result` is frozen. When `result_ready` is high, go to IDLE.
- `in_ready` is 0 in both COMPUTE and DONE. If `in_valid` is high in DONE, it is ignored and the job is accepted in the next IDLE cycle. Upstream must hold `in_valid` and the operands until accepted.
- Arithmetic:
  - operands are unsigned;
  - the full 2·ELEM_WIDTH product is formed, then truncated to ACC_WIDTH;
  - the sum wraps modulo 2^ACC_WIDTH;
  - there is no saturation and no overflow flag.
- `result` holds partial sums during COMPUTE. Its value there is not meaningful; consumers use it only while `result_valid`=1.
- Changes on the operand inputs after acceptance have no effect.

## Timing
- Reset values: state IDLE, `result` all 0, `result_valid`=0, `busy`=0, `in_ready`=1 from the first cycle after reset. `result_id`=ID at all times.
- Compute length is C = N·N·N/LANES cycles (64 at the defaults; 256 with LANES=2).
- Latency: for an accept edge at T, `busy`=1 in cycles T+1..T+C, and `result_valid` is high from edge T+C+1 (T+65 at the defaults).
- `result_valid` stays high, with `result` unchanged, for as long as `result_ready`=0.
- DONE with `result_ready`=1 at edge E: IDLE after E, so the earliest next accept is at edge E+1.
- Back-to-back throughput is 1 job per C+2 cycles.
- Reset in any state, including mid-COMPUTE or DONE, returns all outputs to their reset values at the next edge; the partial job is discarded.

## Structure
- Add to the shared `types` package:
  - enum `pim_tile_state_e`;
  - localparam helper `PIM_GROUPS = N/LANES` (or compute it per instance).
- Counters i, g and k are sized with `$clog2`, with a minimum width of 1.
- Sub-module `pim_mac_lane` (parameters ELEM_WIDTH, ACC_WIDTH): combinational `acc_out = acc_in + trunc(a·b)`. It is instantiated LANES times and selected by (i, j) muxing into the result array.
- Estimated size is about 200 RTL lines.

## Test plan
- Identity: A=I, B[r][c]=r·8+c, `acc_en`=0, defaults, `result_ready`=1 → `result`=B; `result_valid` rises exactly 65 edges after the accept edge; `busy` is high for 64 cycles.
- Accumulate: job 1 with A=B=all 1s and `acc_en`=0 → every element is 8. Job 2 with the same operands and `acc_en`=1 → every element is 16.
- Backpressure: hold `result_ready`=0 for 10 cycles in DONE and assert `in_valid` with new operands → `result_valid` and `result` stay stable and `in_ready`=0 throughout. After `result_ready` pulses, the new job is accepted one cycle later.
- Wrap-around: A=B=all 0xFFFFFFFF, ACC_WIDTH=32 → each product truncates to 0x00000001, so every element is 0x00000008.
- Reset mid-compute: assert `rst` at compute cycle 30 → next cycle `result`=0, `result_valid`=0, `busy`=0, `in_ready`=1. A following identity job gives the correct result.
- LANES=2 instance: random 8-bit values against a reference model → `result` matches, and `result_valid` rises at T+257.
